// File: rtl/emu_step_ctrl.sv
// Turns host go/reset levels into a model clock-enable: each accepted go edge issues STEPS_PER_GO enable cycles.
// Tracks emulated time and step count; the first emu_ce cycle follows go sampling by SYNC_STAGES+1 edges.
module emu_step_ctrl #(
    parameter int unsigned SYNC_STAGES  = 2,
    parameter int unsigned STEPS_PER_GO = 1,
    parameter int unsigned TIME_WIDTH   = 40,
    parameter int unsigned DT_CODE      = 1,
    parameter int unsigned COUNT_WIDTH  = 32
) (
    input  logic                   i_emu_clk,
    input  logic                   i_emu_rst,
    input  logic                   i_go_vio,
    input  logic                   i_rst_vio,
    output logic                   o_emu_ce,
    output logic                   o_model_rst,
    output logic [TIME_WIDTH-1:0]  o_emu_time,
    output logic [COUNT_WIDTH-1:0] o_step_count,
    output logic                   o_busy,
    output logic                   o_done,
    output logic                   o_go_ignored
);

    localparam int unsigned REM_W = $clog2(STEPS_PER_GO + 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DONE
    } state_t;

    logic [SYNC_STAGES-1:0] r_go_sync;
    logic [SYNC_STAGES-1:0] r_rst_sync;
    logic                   r_go_prev;
    logic                   r_go_edge;
    logic                   w_go_s;
    logic                   w_rst_s;

    state_t                 r_state;
    logic [REM_W-1:0]       r_remaining;
    logic                   r_ce;
    logic                   r_busy;
    logic                   r_done;
    logic                   r_go_ignored;
    logic                   r_model_rst;
    logic [TIME_WIDTH-1:0]  r_emu_time;
    logic [COUNT_WIDTH-1:0] r_step_count;

    assign w_go_s  = r_go_sync[SYNC_STAGES-1];
    assign w_rst_s = r_rst_sync[SYNC_STAGES-1];

    // The edge pulse is registered so the FSM acts one edge after go_prev updates.
    always_ff @(posedge i_emu_clk) begin
        if (i_emu_rst) begin
            r_go_sync  <= '0;
            r_rst_sync <= '0;
            r_go_prev  <= 1'b0;
            r_go_edge  <= 1'b0;
        end else begin
            r_go_sync[0]  <= i_go_vio;
            r_rst_sync[0] <= i_rst_vio;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                r_go_sync[i]  <= r_go_sync[i-1];
                r_rst_sync[i] <= r_rst_sync[i-1];
            end
            r_go_prev <= w_go_s;
            r_go_edge <= w_go_s & ~r_go_prev;
        end
    end

    always_ff @(posedge i_emu_clk) begin
        if (i_emu_rst) begin
            r_state      <= ST_IDLE;
            r_remaining  <= '0;
            r_ce         <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_go_ignored <= 1'b0;
            r_model_rst  <= 1'b1;
            r_emu_time   <= '0;
            r_step_count <= '0;
        end else begin
            r_model_rst <= w_rst_s;
            if (w_rst_s) begin
                // Model reset aborts any burst silently; a go edge now is dropped.
                r_state    <= ST_IDLE;
                r_ce       <= 1'b0;
                r_busy     <= 1'b0;
                r_done     <= 1'b0;
                r_emu_time   <= '0;
                r_step_count <= '0;
                if (r_go_edge) begin
                    r_go_ignored <= 1'b1;
                end
            end else begin
                case (r_state)
                    ST_RUN: begin
                        r_emu_time   <= r_emu_time + TIME_WIDTH'(DT_CODE);
                        r_step_count <= r_step_count + COUNT_WIDTH'(1);
                        if (r_go_edge) begin
                            r_go_ignored <= 1'b1;
                        end
                        if (r_remaining == REM_W'(1)) begin
                            r_state <= ST_DONE;
                            r_ce    <= 1'b0;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                        end else begin
                            r_remaining <= r_remaining - REM_W'(1);
                        end
                    end
                    default: begin
                        r_done <= 1'b0;
                        if (r_go_edge) begin
                            r_state     <= ST_RUN;
                            r_remaining <= REM_W'(STEPS_PER_GO);
                            r_ce        <= 1'b1;
                            r_busy      <= 1'b1;
                        end else begin
                            r_state <= ST_IDLE;
                            r_ce    <= 1'b0;
                            r_busy  <= 1'b0;
                        end
                    end
                endcase
            end
        end
    end

    assign o_emu_ce     = r_ce;
    assign o_model_rst  = r_model_rst;
    assign o_emu_time   = r_emu_time;
    assign o_step_count = r_step_count;
    assign o_busy       = r_busy;
    assign o_done       = r_done;
    assign o_go_ignored = r_go_ignored;

endmodule

// File: tb/tb_emu_step_ctrl.sv
// Drives four emu_step_ctrl configurations (default, burst 4/dt 3, burst 8, 4-bit wrapping time)
// and compares outputs against step totals computed from the go/reset rules.
module tb_emu_step_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        emu_rst;
    logic        go   [4];
    logic        rv   [4];
    logic        ce   [4];
    logic        mrst [4];
    logic        busy [4];
    logic        done [4];
    logic        ign  [4];
    logic [63:0] tim  [4];
    logic [63:0] cnt  [4];

    int ce_cnt   [4];
    int done_cnt [4];
    int checks   = 0;
    int failures = 0;

    function automatic int p_steps(int i);
        return (i == 1) ? 4 : (i == 2) ? 8 : 1;
    endfunction

    function automatic int p_dt(int i);
        return (i == 1) ? 3 : (i == 3) ? 5 : 1;
    endfunction

    function automatic int p_tw(int i);
        return (i == 3) ? 4 : 40;
    endfunction

    function automatic logic [63:0] exp_time(int i, int steps);
        logic [63:0] m;
        m = (64'd1 << p_tw(i)) - 64'd1;
        return (64'(steps) * 64'(p_dt(i))) & m;
    endfunction

    generate
        for (genvar g = 0; g < 4; g++) begin : g_dut
            localparam int ST = (g == 1) ? 4 : (g == 2) ? 8 : 1;
            localparam int DT = (g == 1) ? 3 : (g == 3) ? 5 : 1;
            localparam int TW = (g == 3) ? 4 : 40;
            logic          l_ce, l_mrst, l_busy, l_done, l_ign;
            logic [TW-1:0] l_time;
            logic [31:0]   l_cnt;
            emu_step_ctrl #(
                .SYNC_STAGES(2), .STEPS_PER_GO(ST), .TIME_WIDTH(TW),
                .DT_CODE(DT), .COUNT_WIDTH(32)
            ) u_dut (
                .i_emu_clk(clk), .i_emu_rst(emu_rst), .i_go_vio(go[g]), .i_rst_vio(rv[g]),
                .o_emu_ce(l_ce), .o_model_rst(l_mrst), .o_emu_time(l_time),
                .o_step_count(l_cnt), .o_busy(l_busy), .o_done(l_done), .o_go_ignored(l_ign)
            );
            assign ce[g]   = l_ce;
            assign mrst[g] = l_mrst;
            assign busy[g] = l_busy;
            assign done[g] = l_done;
            assign ign[g]  = l_ign;
            assign tim[g]  = 64'(l_time);
            assign cnt[g]  = 64'(l_cnt);
        end
    endgenerate

    always @(negedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (ce[i] === 1'b1) ce_cnt[i]++;
            if (done[i] === 1'b1) done_cnt[i]++;
        end
    end

    task automatic tick(int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic pulse(int i, int hi, int lo);
        go[i] = 1'b1;
        tick(hi);
        go[i] = 1'b0;
        tick(lo);
    endtask

    task automatic wait_done(int i, int budget);
        int n;
        n = 0;
        while (done[i] !== 1'b1 && n < budget) begin
            tick();
            n++;
        end
        chk("done_within_budget", 64'(done[i]), 64'd1);
    endtask

    int steps_exp [4];

    initial begin
        int n, seen, base_ce, base_dn, np, st;
        emu_rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            go[i] = 1'b0;
            rv[i] = 1'b1;
            steps_exp[i] = 0;
        end
        tick(3);
        for (int i = 0; i < 4; i++) begin
            chk("rst_model_rst", 64'(mrst[i]), 64'd1);
            chk("rst_emu_ce", 64'(ce[i]), 64'd0);
            chk("rst_emu_time", tim[i], 64'd0);
            chk("rst_step_count", cnt[i], 64'd0);
            chk("rst_busy", 64'(busy[i]), 64'd0);
            chk("rst_done", 64'(done[i]), 64'd0);
            chk("rst_go_ignored", 64'(ign[i]), 64'd0);
        end
        emu_rst = 1'b0;
        tick(5);
        for (int i = 0; i < 4; i++) chk("model_rst_held", 64'(mrst[i]), 64'd1);
        for (int i = 0; i < 4; i++) rv[i] = 1'b0;
        tick(2);
        for (int i = 0; i < 4; i++) chk("model_rst_before_fall", 64'(mrst[i]), 64'd1);
        tick(1);
        for (int i = 0; i < 4; i++) chk("model_rst_fall", 64'(mrst[i]), 64'd0);

        // Single step: latency and post-step values.
        go[0] = 1'b1;
        n = 0;
        while (ce[0] !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        chk("single_latency", 64'(n), 64'd4);
        chk("single_time_before_step", tim[0], 64'd0);
        tick();
        chk("single_ce_one_cycle", 64'(ce[0]), 64'd0);
        chk("single_time", tim[0], exp_time(0, 1));
        chk("single_count", cnt[0], 64'd1);
        chk("single_done", 64'(done[0]), 64'd1);
        chk("single_busy", 64'(busy[0]), 64'd0);
        tick();
        chk("single_done_pulse_len", 64'(done[0]), 64'd0);
        go[0] = 1'b0;
        tick(5);

        // Model reset clears counters.
        rv[0] = 1'b1;
        tick(5);
        chk("rstvio_time_clear", tim[0], 64'd0);
        chk("rstvio_count_clear", cnt[0], 64'd0);
        rv[0] = 1'b0;
        tick(5);
        chk("rstvio_released", 64'(mrst[0]), 64'd0);

        // Host loop: 25 pulses, 10 high / 10 low.
        base_ce = ce_cnt[0];
        base_dn = done_cnt[0];
        repeat (25) pulse(0, 10, 10);
        chk("host_ce_cycles", 64'(ce_cnt[0] - base_ce), 64'd25);
        chk("host_done_pulses", 64'(done_cnt[0] - base_dn), 64'd25);
        chk("host_time", tim[0], exp_time(0, 25));
        chk("host_count", cnt[0], 64'd25);
        chk("host_go_ignored", 64'(ign[0]), 64'd0);

        // Burst of 4 with a second go edge arriving mid-burst.
        base_ce = ce_cnt[1];
        base_dn = done_cnt[1];
        go[1] = 1'b1;
        tick(1);
        go[1] = 1'b0;
        tick(1);
        go[1] = 1'b1;
        wait_done(1, 40);
        tick(10);
        steps_exp[1] = 4;
        chk("overlap_ce_cycles", 64'(ce_cnt[1] - base_ce), 64'd4);
        chk("overlap_done_pulses", 64'(done_cnt[1] - base_dn), 64'd1);
        chk("overlap_time", tim[1], exp_time(1, steps_exp[1]));
        chk("overlap_count", cnt[1], 64'(steps_exp[1]));
        chk("overlap_go_ignored", 64'(ign[1]), 64'd1);
        go[1] = 1'b0;
        tick(5);

        // Burst of 8 aborted by rst_vio after 3 steps.
        base_dn = done_cnt[2];
        go[2] = 1'b1;
        n = 0;
        seen = 0;
        while (seen < 3 && n < 40) begin
            tick();
            n++;
            if (ce[2] === 1'b1) seen++;
        end
        chk("abort_steps_before_rst", 64'(seen), 64'd3);
        rv[2] = 1'b1;
        n = 0;
        do begin
            tick();
            n++;
        end while (ce[2] === 1'b1 && n < 10);
        chk("abort_ce_fall_in_time", 64'(n <= 3), 64'd1);
        chk("abort_time", tim[2], 64'd0);
        chk("abort_count", cnt[2], 64'd0);
        chk("abort_busy", 64'(busy[2]), 64'd0);
        tick(5);
        chk("abort_no_done", 64'(done_cnt[2] - base_dn), 64'd0);
        chk("abort_model_rst", 64'(mrst[2]), 64'd1);
        go[2] = 1'b0;
        rv[2] = 1'b0;
        tick(6);
        base_ce = ce_cnt[2];
        base_dn = done_cnt[2];
        go[2] = 1'b1;
        wait_done(2, 40);
        tick(3);
        chk("fresh_ce_cycles", 64'(ce_cnt[2] - base_ce), 64'd8);
        chk("fresh_done_pulses", 64'(done_cnt[2] - base_dn), 64'd1);
        chk("fresh_time", tim[2], exp_time(2, 8));
        chk("fresh_count", cnt[2], 64'd8);
        go[2] = 1'b0;
        tick(3);

        // 4-bit time accumulator wrap: 5, 10, 15, 4.
        for (int p = 1; p <= 4; p++) begin
            pulse(3, 3, 8);
            steps_exp[3] = p;
            chk("wrap_time", tim[3], exp_time(3, p));
        end

        // Randomized well-spaced pulse trains: every edge must be accepted.
        for (int k = 0; k < 2; k++) begin
            st = (k == 0) ? 1 : 3;
            np = int'($urandom_range(5, 10));
            base_ce = ce_cnt[st];
            base_dn = done_cnt[st];
            repeat (np) begin
                pulse(st, int'($urandom_range(1, 4)), int'($urandom_range(10, 20)));
                steps_exp[st] += p_steps(st);
            end
            chk("rand_ce_cycles", 64'(ce_cnt[st] - base_ce), 64'(np * p_steps(st)));
            chk("rand_done_pulses", 64'(done_cnt[st] - base_dn), 64'(np));
            chk("rand_time", tim[st], exp_time(st, steps_exp[st]));
            chk("rand_count", cnt[st], 64'(steps_exp[st]));
        end
        chk("rand_wrap_go_ignored", 64'(ign[3]), 64'd0);

        // go edge coinciding with model reset is dropped and flagged.
        base_ce = ce_cnt[0];
        rv[0] = 1'b1;
        go[0] = 1'b1;
        tick(10);
        chk("coinc_no_ce", 64'(ce_cnt[0] - base_ce), 64'd0);
        chk("coinc_go_ignored", 64'(ign[0]), 64'd1);
        chk("coinc_time", tim[0], 64'd0);
        go[0] = 1'b0;
        tick(4);

        // Reset release together with a go edge: go is accepted.
        rv[0] = 1'b0;
        go[0] = 1'b1;
        wait_done(0, 20);
        chk("release_go_count", cnt[0], 64'd1);
        chk("release_go_time", tim[0], exp_time(0, 1));
        go[0] = 1'b0;
        tick(3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/emu_step_ctrl.md
Name: emu_step_ctrl

Overview:
Emulator-side counterpart of the sim-control VIO interface. It receives the go/reset control levels driven by the host or testbench and converts them into a clock-enable for the analog model: each go pulse advances the model by exactly STEPS_PER_GO emulator time steps. It also tracks emulated time and step count for readback. It sits between the VIO/sim_ctrl outputs and the model's clock-enable and reset inputs.

Parameters:
SYNC_STAGES, 2, number of synchronizer flops on go_vio and rst_vio (minimum 1)
STEPS_PER_GO, 1, number of emu_ce cycles issued per accepted go rising edge (minimum 1)
TIME_WIDTH, 40, width of emu_time accumulator
DT_CODE, 1, fixed-point time increment added per step (units of DT_MSDSL LSB)
COUNT_WIDTH, 32, width of step_count

Ports:
emu_clk  input  1  emulator clock
emu_rst  input  1  synchronous active-high reset
go_vio  input  1  step request level; a rising edge requests one burst
rst_vio  input  1  model reset request level
emu_ce  output  1  model clock enable; the model advances on every emu_clk edge where this is high
model_rst  output  1  registered reset to the model
emu_time  output  TIME_WIDTH  accumulated time, in DT_CODE units
step_count  output  COUNT_WIDTH  total steps taken since the last reset
busy  output  1  high while a burst is in progress
done  output  1  one-cycle pulse after a burst's last step
go_ignored  output  1  sticky flag: a go edge arrived while busy or while in model reset

Behaviour:
- Reset:
  - emu_rst is sampled on the emu_clk rising edge.
  - While asserted: emu_ce=0, model_rst=1, emu_time=0, step_count=0, busy=0, done=0, go_ignored=0.
  - Synchronizer flops and the edge-detect flop clear to 0.
- Synchronization and edge detection:
  - go_vio and rst_vio each pass through SYNC_STAGES flops, giving go_s and rst_s.
  - go_prev is a register holding go_s from the previous cycle.
  - go_edge = go_s & ~go_prev.
  - Latency: with go_vio first sampled high at edge k, the first emu_ce-high cycle starts after edge k+SYNC_STAGES+1.
- model_rst:
  - Registered value of (emu_rst | rst_s).
  - While rst_s=1: emu_time and step_count are held at 0, the FSM is forced to IDLE, and any burst in progress is aborted on the next edge.
  - done is not pulsed on an abort.
- FSM:
  - IDLE:
    - On go_edge with rst_s=0, go to RUN, load remaining=STEPS_PER_GO, set busy=1.
    - On go_edge with rst_s=1, stay in IDLE and set go_ignored.
  - RUN:
    - emu_ce=1 every cycle, decoded from the registered state.
    - At each edge in RUN: emu_time += DT_CODE, step_count += 1, remaining -= 1.
    - When remaining reaches 1 at an edge, go to DONE.
  - DONE:
    - Lasts exactly one cycle, with emu_ce=0, busy=0, done=1.
    - Then go to IDLE.
    - A go_edge seen in DONE is accepted: the FSM goes straight to RUN.
- Any go_edge while in RUN sets go_ignored. It is not queued.
- Output values by state:
  - IDLE: emu_ce=0, busy=0, done=0.
  - RUN: emu_ce=1, busy=1, done=0.
- emu_time reflects the model state after each step: it updates on the same edge the model consumes emu_ce.
- Arithmetic:
  - emu_time wraps modulo 2^TIME_WIDTH.
  - step_count wraps modulo 2^COUNT_WIDTH.
  - No saturation is applied to either.
- go_ignored is cleared only by emu_rst.
- Simultaneous events:
  - rst_s=1 in the same cycle as go_edge: the reset wins, go_ignored is set, and no emu_ce is issued.
  - rst_s falling and go_edge in the same cycle: go is accepted.

Test Plan:
- Reset then idle: emu_rst high 3 cycles with go_vio=0 -> model_rst=1, emu_ce=0, emu_time=0, step_count=0, go_ignored=0; after rst_vio=0, model_rst falls SYNC_STAGES+1 edges later.
- Single step (defaults): rst_vio=0, go_vio raised at edge k -> emu_ce high for exactly 1 cycle starting after edge k+3; emu_time=1 and step_count=1 after that edge; done pulses the next cycle.
- Pulse sequence mirroring the host loop: 25 go pulses, each 10 cycles high and 10 low -> exactly 25 emu_ce cycles, emu_time=25, step_count=25, go_ignored=0.
- Burst and overlap: STEPS_PER_GO=4, DT_CODE=3; a second go edge arrives during RUN -> 4 emu_ce cycles only, emu_time=12, go_ignored=1.
- Reset mid-burst: STEPS_PER_GO=8; rst_vio raised after 3 steps -> emu_ce falls within SYNC_STAGES+1 cycles, emu_time=0, step_count=0, no done pulse; the next go after rst_vio falls yields a fresh burst of 8.
- Wrap-around: TIME_WIDTH=4, DT_CODE=5, 4 single-step go pulses -> emu_time sequence 5, 10, 15, 4.
